// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM of the multicycle RV32I core: drives the shared datapath through
// fetch/decode/execute/memory/write-back, paces the memory handshake and traps on faults.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [6:0]           opcode_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic [1:0]           alu_a_sel_o,
    output logic                 alu_b_sel_o,
    output logic [1:0]           alu_op_o,
    output logic                 rf_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 instr_retired_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic                 illegal_instr_o,
    output logic                 bus_error_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILLEGAL
    } class_e;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e                 state_q, state_d;
    class_e                 class_q, class_d;
    class_e                 dec_class;
    logic [TW-1:0]          timer_q, timer_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   illegal_q, illegal_d;
    logic                   bus_err_q, bus_err_d;
    logic                   wait_expired;
    logic [1:0]             a_sel, op_sel;
    logic                   b_sel;

    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode_i)
            7'b0110111: dec_class = C_LUI;
            7'b0010111: dec_class = C_AUIPC;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b1100011: dec_class = C_BRANCH;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b0010011: dec_class = C_OPIMM;
            7'b0110011: dec_class = C_OP;
            default:    dec_class = C_ILLEGAL;
        endcase
    end

    always_comb begin
        a_sel  = 2'd0;
        b_sel  = 1'b1;
        op_sel = 2'd0;
        case (class_q)
            C_LUI:    a_sel = 2'd2;
            C_AUIPC:  a_sel = 2'd1;
            C_JAL:    a_sel = 2'd1;
            C_OP:     begin b_sel = 1'b0; op_sel = 2'd2; end
            C_OPIMM:  op_sel = 2'd2;
            C_BRANCH: begin b_sel = 1'b0; op_sel = 2'd1; end
            default:  ;
        endcase
    end

    // Only meaningful while a request is outstanding; a same-cycle ready wins over the timeout.
    assign wait_expired = (TIMEOUT_CYCLES != 0) && !mem_ready_i && (timer_q == TO_LAST);

    always_comb begin
        state_d         = state_q;
        class_d         = class_q;
        illegal_d       = illegal_q;
        bus_err_d       = bus_err_q;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = 2'd0;
        alu_a_sel_o     = 2'd0;
        alu_b_sel_o     = 1'b0;
        alu_op_o        = 2'd0;
        rf_we_o         = 1'b0;
        wb_sel_o        = 2'd0;
        instr_retired_o = 1'b0;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == C_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_a_sel_o = a_sel;
                alu_b_sel_o = b_sel;
                alu_op_o    = op_sel;
                if (class_q == C_BRANCH) begin
                    pc_we_o         = 1'b1;
                    pc_sel_o        = branch_taken_i ? 2'd1 : 2'd0;
                    instr_retired_o = 1'b1;
                    state_d         = S_FETCH;
                end else if (class_q == C_LOAD || class_q == C_STORE) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                alu_a_sel_o = a_sel;
                alu_b_sel_o = b_sel;
                alu_op_o    = op_sel;
                mem_req_o   = 1'b1;
                mem_we_o    = (class_q == C_STORE);
                if (mem_ready_i) begin
                    if (class_q == C_STORE) begin
                        pc_we_o         = 1'b1;
                        instr_retired_o = 1'b1;
                        state_d         = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                alu_a_sel_o     = a_sel;
                alu_b_sel_o     = b_sel;
                alu_op_o        = op_sel;
                rf_we_o         = 1'b1;
                pc_we_o         = 1'b1;
                instr_retired_o = 1'b1;
                if (class_q == C_LOAD) begin
                    wb_sel_o = 2'd1;
                end else if (class_q == C_JAL || class_q == C_JALR) begin
                    wb_sel_o = 2'd2;
                    pc_sel_o = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_RESET;
        endcase
    end

    // Wait counter restarts whenever the state changes, so it always measures the current access.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (mem_req_o && !mem_ready_i) begin
            timer_d = timer_q + TW'(1);
        end
        instret_d = instret_q + INSTRET_W'(instr_retired_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_RESET;
            class_q   <= C_ILLEGAL;
            timer_q   <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            timer_q   <= timer_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign instret_o       = instret_q;
    assign illegal_instr_o = illegal_q;
    assign bus_error_o     = bus_err_q;
    assign state_o         = state_q;

endmodule
